// File: rtl/cordic_sincos.sv
// cordic_sincos: iterative CORDIC rotation engine, sine and cosine of a
// signed fixed-point angle in [-pi, pi], ITERS_PER_CYCLE rotations/clock.
// Ports:
//   clk     : clock, rising edge
//   reset   : synchronous active-low reset
//   clk_en  : global enable, low freezes every register
//   start   : request, taken when ready=1 and clk_en=1
//   theta   : signed angle in radians, FRACS fractional bits
//   ready   : high while idle
//   done    : one enabled-cycle pulse when cos_out/sin_out update
//   cos_out : signed cosine, held until next done
//   sin_out : signed sine, held until next done
module cordic_sincos #(
  parameter int FRACS           = 21,
  parameter int INTS            = 2,
  parameter int WIDTH           = INTS + FRACS + 1,
  parameter int ITERATIONS      = 16,
  parameter int ITERS_PER_CYCLE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [WIDTH-1:0] theta,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] cos_out,
  output logic [WIDTH-1:0] sin_out
);

  localparam int STEPS = ITERATIONS / ITERS_PER_CYCLE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int SH    = 30 - FRACS;
  localparam int IPC   = ITERS_PER_CYCLE;

  // Constants are kept at 30 fractional bits and rounded to FRACS.
  function automatic logic [WIDTH-1:0] q30(input longint v);
    longint r;
    r = v;
    if (SH > 0)
      r = (v + (longint'(1) <<< (SH > 0 ? SH - 1 : 0))) >>> SH;
    return r[WIDTH-1:0];
  endfunction

  function automatic longint atan30(input int i);
    longint r;
    unique case (1'b1)
      (i == 0): r = 64'd843314857;
      (i == 1): r = 64'd497837830;
      (i == 2): r = 64'd263043837;
      (i == 3): r = 64'd133525159;
      (i == 4): r = 64'd67021687;
      (i == 5): r = 64'd33543516;
      (i == 6): r = 64'd16775851;
      (i == 7): r = 64'd8388437;
      (i == 8): r = 64'd4194283;
      (i == 9): r = 64'd2097149;
      default:  r = longint'(1) <<< (30 - i);
    endcase
    return r;
  endfunction

  function automatic logic [30*WIDTH-1:0] mk_tab();
    logic [30*WIDTH-1:0] t;
    t = '0;
    for (int i = 0; i < 30; i++)
      t[i*WIDTH +: WIDTH] = q30(atan30(i));
    return t;
  endfunction

  localparam logic [WIDTH-1:0] PI_C   = q30(64'd3373259426);
  localparam logic [WIDTH-1:0] PI_2_C = q30(64'd1686629713);
  localparam logic [WIDTH-1:0] K_C    = q30(64'd652032874);
  localparam logic [30*WIDTH-1:0] ATAN = mk_tab();

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state;
  state_t state_n;

  logic [CW-1:0]           cnt;
  logic                    last;
  logic                    flip_q;
  logic signed [WIDTH-1:0] x_q;
  logic signed [WIDTH-1:0] y_q;
  logic signed [WIDTH-1:0] z_q;
  logic signed [WIDTH-1:0] x_n;
  logic signed [WIDTH-1:0] y_n;
  logic signed [WIDTH-1:0] z_n;
  logic signed [WIDTH-1:0] th_s;
  logic signed [WIDTH-1:0] pi_s;
  logic signed [WIDTH-1:0] pi2_s;
  logic signed [WIDTH-1:0] z_fold;
  logic                    flip_fold;

  assign last  = (cnt == CW'(STEPS - 1));
  assign th_s  = theta;
  assign pi_s  = PI_C;
  assign pi2_s = PI_2_C;

  // State register
  always_ff @(posedge clk) begin
    if (!reset)
      state <= IDLE;
    else if (clk_en)
      state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = RUN;
      RUN:  if (last)  state_n = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready = (state == IDLE);
  end

  // Fold into [-pi/2, pi/2]; the half-turn is undone by negating results.
  always_comb begin
    z_fold    = th_s;
    flip_fold = 1'b0;
    unique case (1'b1)
      (th_s > pi2_s): begin
        z_fold    = th_s - pi_s;
        flip_fold = 1'b1;
      end
      (th_s < -pi2_s): begin
        z_fold    = th_s + pi_s;
        flip_fold = 1'b1;
      end
      default: begin
        z_fold    = th_s;
        flip_fold = 1'b0;
      end
    endcase
  end

  // Unrolled micro-rotations for this step
  for (genvar k = 0; k < IPC; k++) begin : g_rot
    logic [4:0]              sh;
    logic signed [WIDTH-1:0] a;
    logic signed [WIDTH-1:0] xi;
    logic signed [WIDTH-1:0] yi;
    logic signed [WIDTH-1:0] zi;
    logic signed [WIDTH-1:0] xo;
    logic signed [WIDTH-1:0] yo;
    logic signed [WIDTH-1:0] zo;
    logic                    neg;

    if (k == 0) begin : g_first
      assign xi = x_q;
      assign yi = y_q;
      assign zi = z_q;
    end else begin : g_next
      assign xi = g_rot[k-1].xo;
      assign yi = g_rot[k-1].yo;
      assign zi = g_rot[k-1].zo;
    end

    assign sh  = 5'(int'(cnt) * IPC + k);
    assign a   = ATAN[sh*WIDTH +: WIDTH];
    assign neg = zi[WIDTH-1];
    assign xo  = neg ? xi + (yi >>> sh) : xi - (yi >>> sh);
    assign yo  = neg ? yi - (xi >>> sh) : yi + (xi >>> sh);
    assign zo  = neg ? zi + a : zi - a;
  end

  assign x_n = g_rot[IPC-1].xo;
  assign y_n = g_rot[IPC-1].yo;
  assign z_n = g_rot[IPC-1].zo;

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      flip_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      done    <= 1'b0;
      cos_out <= '0;
      sin_out <= '0;
    end else if (clk_en) begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          x_q    <= K_C;
          y_q    <= '0;
          z_q    <= z_fold;
          flip_q <= flip_fold;
          cnt    <= '0;
        end
      end else begin
        x_q <= x_n;
        y_q <= y_n;
        z_q <= z_n;
        cnt <= cnt + CW'(1);
        if (last) begin
          cnt     <= '0;
          done    <= 1'b1;
          cos_out <= flip_q ? -x_n : x_n;
          sin_out <= flip_q ? -y_n : y_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_cordic_sincos.sv
// tb_cordic_sincos: scoreboard bench for cordic_sincos, default build
// plus a 24-iteration / 8-per-cycle build.
module tb_cordic_sincos;

  localparam int W      = 24;
  localparam int ONE    = 2097152;
  localparam int PI_I   = 6588397;
  localparam int STEPS  = 4;
  localparam int STEPSF = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         clk_en;
  logic         start;
  logic [W-1:0] theta;
  logic         ready;
  logic         done;
  logic [W-1:0] cos_out;
  logic [W-1:0] sin_out;
  logic         start_f;
  logic [W-1:0] theta_f;
  logic         ready_f;
  logic         done_f;
  logic [W-1:0] cos_f;
  logic [W-1:0] sin_f;

  always #5 clk = ~clk;

  cordic_sincos dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .start(start), .theta(theta), .ready(ready),
    .done(done), .cos_out(cos_out), .sin_out(sin_out)
  );

  cordic_sincos #(
    .FRACS(21), .INTS(2),
    .ITERATIONS(24), .ITERS_PER_CYCLE(8)
  ) dut_f (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .start(start_f), .theta(theta_f), .ready(ready_f),
    .done(done_f), .cos_out(cos_f), .sin_out(sin_f)
  );

  typedef struct {
    logic [W-1:0] th;
    int           ec;
    int           es;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input longint obs,
                     input longint exp, input longint tol);
    longint d;
    n_cmp++;
    d = obs - exp;
    if (d < 0) d = -d;
    assert (d <= tol) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d tol %0d",
             tag, obs, exp, tol);
    end
  endtask

  function automatic int rf(input logic [W-1:0] th, input bit s);
    real a;
    real v;
    a = $itor($signed(th)) / 2097152.0;
    v = s ? $sin(a) : $cos(a);
    v = v * 2097152.0;
    return $rtoi(v < 0.0 ? v - 0.5 : v + 0.5);
  endfunction

  function automatic logic [W-1:0] rnd_angle();
    int v;
    v = int'($urandom_range(0, 2 * PI_I)) - PI_I;
    return W'(v);
  endfunction

  // Scoreboard side: one pop per done pulse
  always @(negedge clk) begin
    if (done && clk_en) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("cos", longint'($signed(cos_out)), e.ec, 128);
        chk("sin", longint'($signed(sin_out)), e.es, 128);
        chk("latency", cyc, e.due, 0);
        chk("ready_at_done", longint'(ready), 1, 0);
      end
    end
  end

  task automatic issue(input logic [W-1:0] th, input int lat,
                       input bit push);
    exp_t e;
    if (push) begin
      e.th  = th;
      e.ec  = rf(th, 1'b0);
      e.es  = rf(th, 1'b1);
      e.due = cyc + 1 + lat;
      sb.push_back(e);
    end
    start = 1'b1;
    theta = th;
    @(posedge clk);
    #1;
    start = 1'b0;
    theta = W'($urandom);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("drain", sb.size(), 0, 0);
  endtask

  task automatic run_fast(input logic [W-1:0] th);
    int n;
    start_f = 1'b1;
    theta_f = th;
    @(posedge clk);
    #1;
    start_f = 1'b0;
    n = 0;
    while (!done_f && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("fast_latency", n, STEPSF, 0);
    chk("fast_cos", longint'($signed(cos_f)), rf(th, 1'b0), 16);
    chk("fast_sin", longint'($signed(sin_f)), rf(th, 1'b1), 16);
  endtask

  int dirs[5] = '{0, 3294199, -1647099, 6291456, -6291456};

  initial begin
    bit got;
    reset   = 1'b0;
    clk_en  = 1'b1;
    start   = 1'b0;
    theta   = '0;
    start_f = 1'b0;
    theta_f = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", longint'(ready), 1, 0);
    chk("rst_done", longint'(done), 0, 0);
    chk("rst_cos", longint'($signed(cos_out)), 0, 0);
    chk("rst_sin", longint'($signed(sin_out)), 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed angles, including folded ones
    for (int i = 0; i < 5; i++) begin
      issue(W'(dirs[i]), STEPS, 1'b1);
      drain(20);
    end

    // Back-to-back, new start in each done cycle, stray start in RUN
    issue(rnd_angle(), STEPS, 1'b1);
    for (int i = 0; i < 99; i++) begin
      @(posedge clk);
      #1;
      start = 1'b1;
      theta = rnd_angle();
      @(posedge clk);
      #1;
      start = 1'b0;
      got = 1'b0;
      for (int j = 0; j < 10 && !got; j++) begin
        @(negedge clk);
        if (done) got = 1'b1;
      end
      chk("done_seen", longint'(got), 1, 0);
      if (!got) break;
      issue(rnd_angle(), STEPS, 1'b1);
    end
    drain(20);

    // Three stalled cycles mid-RUN
    issue(W'(1000000), STEPS + 3, 1'b1);
    @(posedge clk);
    #1;
    clk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clk_en = 1'b1;
    drain(20);

    // Reset in RUN cycle 2 aborts
    issue(W'(-2500000), 0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("abort_ready", longint'(ready), 1, 0);
    chk("abort_done", longint'(done), 0, 0);
    chk("abort_cos", longint'($signed(cos_out)), 0, 0);
    chk("abort_sin", longint'($signed(sin_out)), 0, 0);
    repeat (8) @(posedge clk);
    #1;

    // Reset wins over start
    issue(W'(1000000), STEPS, 1'b1);
    drain(20);
    reset = 1'b0;
    start = 1'b1;
    theta = W'(500000);
    @(posedge clk);
    #1;
    start = 1'b0;
    reset = 1'b1;
    chk("rst_start_ready", longint'(ready), 1, 0);
    chk("rst_start_cos", longint'($signed(cos_out)), 0, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("rst_start_idle", longint'(ready), 1, 0);

    // 24 iterations, 8 per cycle
    for (int i = 0; i < 5; i++) run_fast(W'(dirs[i]));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
